fir_tap_sequencer: RTL and testbench
====================================

# fir_tap_sequencer

Initiator side of the single-precision FP multiply-accumulate DSP interface (`x_i`/`h_i`/`fpopmode_bit_i` in, `y_o` out) used by the FIR filter.
- Holds the coefficient bank and the sample delay line.
- Per accepted input sample, streams NTAPS (sample, coefficient) pairs into the DSP slice, then captures the accumulated result from the DSP output.
- Presents the result on a valid/ready output port.
- Sits between the sample source and the FIR output sink, wrapping one DSP58 instance.

## Interface
- NTAPS, 8, number of filter taps (≥2).
- DSP_LAT, 4, DSP cycles from a tap presented on `x_o`/`h_o` to its accumulation being visible on `y_i`.
- AW, $clog2(NTAPS), coefficient address width.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ce_i  in  1  clock enable; low freezes all state. Top level routes the same signal to the DSP `ce_i`.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  AW  coefficient index.
- coef_data_i  in  32  IEEE-754 single coefficient.
- s_valid_i  in  1  input sample valid.
- s_ready_o  out  1  input sample ready.
- s_data_i  in  32  IEEE-754 single sample.
- x_o  out  32  to DSP `x_i`.
- h_o  out  32  to DSP `h_i`.
- fpopmode_bit_o  out  1  to DSP `fpopmode_bit_i`:
  - 1 = product starts a new accumulation.
  - 0 = product adds to the running sum.
- y_i  in  32  from DSP `y_o`.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  result ready.
- m_data_o  out  32  filter output sample.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - `s_ready_o`=1.
  - On `s_valid_i && s_ready_o && ce_i`: shift `s_data_i` into `dline[0]`, `dline[k]`←`dline[k-1]`, oldest sample dropped, tap counter ←0, go to RUN.
- RUN, one tap per enabled cycle:
  - Registered outputs `x_o`←`dline[k]`, `h_o`←`coef[k]`, `fpopmode_bit_o`←(k==0).
  - After tap NTAPS-1, go to DRAIN with counter ←0.
- DRAIN:
  - `x_o`=`h_o`=0, `fpopmode_bit_o`=0. The accumulator adds +0.0, so the sum is unchanged.
  - Count DSP_LAT enabled cycles, then register `m_data_o`←`y_i` and go to OUT.
- OUT: `m_valid_o`=1, `m_data_o` stable. On `m_ready_i`, return to IDLE.
- `s_ready_o` is 1 only in IDLE. There is no overlap between samples.
- Coefficient writes take effect only in IDLE with `ce_i`=1. Writes in RUN/DRAIN/OUT are ignored, so coefficients never change mid-sample.
- Arithmetic: none in this block. All data are 32-bit opaque words passed through unmodified.

## Timing
- Reset values after any enabled edge with `rst_i`=1:
  - State IDLE, all `dline` and `coef` entries 0x00000000.
  - `x_o`=`h_o`=0, `fpopmode_bit_o`=0, `m_valid_o`=0, `m_data_o`=0.
  - `s_ready_o`=1 from the first cycle after reset.
- `rst_i` takes priority over `ce_i`.
- Reset mid-RUN/DRAIN/OUT aborts the sample and clears pending `m_valid_o`. The partial DSP accumulation is discarded, because the next sample's tap 0 carries `fpopmode_bit_o`=1.
- Handshake at edge T places tap k on `x_o`/`h_o` after edge T+1+k, for k=0..NTAPS-1.
- `y_i` is sampled at edge T+NTAPS+DSP_LAT. `m_valid_o` rises after that edge.
  - Accept-to-valid latency: NTAPS+DSP_LAT cycles.
  - Throughput: one sample per NTAPS+DSP_LAT+2 cycles at best.
- `m_valid_o`, once high, stays high with `m_data_o` unchanged until the edge where `m_ready_i`=1. The next sample can be accepted no earlier than the following edge.
- `ce_i`=0 cycles are not counted. All latencies above are in enabled cycles.
- `coef_we_i` and a sample handshake on the same IDLE edge: both take effect. The new coefficient is used for this sample.

## Configuration
- FIR_TAP_SEQ_FLUSH_EN defined:
  - Adds port `flush_i` (in, 1).
  - In IDLE with `ce_i`=1, `flush_i`=1 clears every `dline` entry to 0x00000000 in one cycle and holds `s_ready_o`=0 that cycle.
  - `flush_i` is ignored in other states.
  - `flush_i` together with `s_valid_i`: flush wins, sample not accepted.
- Undefined: no `flush_i` port. The delay line clears only on `rst_i`.

## Test plan
Use NTAPS=4, DSP_LAT=4 and a behavioural FP MAC model on `x_o`/`h_o`/`y_i`.
1. Impulse: coefs {5.0, 7.0, 1.0, 5.0} (0x40A00000, 0x40E00000, 0x3F800000, 0x40A00000); samples 1.0, 0, 0, 0, 0 -> `m_data_o` sequence 5.0, 7.0, 1.0, 5.0, 0; each `m_valid_o` 8 cycles after accept.
2. Constant input: all coefs 1.0, four samples of 5.0 -> outputs 5.0, 10.0, 15.0, 20.0 (0x41A00000).
3. Backpressure: hold `m_ready_i`=0 for 10 cycles -> `m_valid_o` and `m_data_o` stable, `s_ready_o`=0 throughout; release -> IDLE next cycle.
4. Coefficient write during RUN (addr 0, 7.0) -> ignored, output unchanged vs. golden; the same write in IDLE -> used on the next sample.
5. `ce_i` low for 3 cycles mid-RUN -> `x_o`/`h_o` frozen, latency extends by exactly 3 cycles, result correct.
6. Reset asserted in DRAIN -> `m_valid_o` never rises for that sample; the next sample's output is correct with all-zero history and zero coefs (0x00000000).

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: streams delay-line/coefficient pairs into an FP MAC DSP.
// Define FIR_TAP_SEQ_FLUSH_EN to add the flush_i delay-line clear port.
module fir_tap_sequencer #(
  parameter int NTAPS   = 8,
  parameter int DSP_LAT = 4,
  parameter int AW      = $clog2(NTAPS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
`ifdef FIR_TAP_SEQ_FLUSH_EN
  input  logic          flush_i,
`endif
  input  logic          coef_we_i,
  input  logic [AW-1:0] coef_addr_i,
  input  logic [31:0]   coef_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [31:0]   s_data_i,
  output logic [31:0]   x_o,
  output logic [31:0]   h_o,
  output logic          fpopmode_bit_o,
  input  logic [31:0]   y_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [31:0]   m_data_o
);

  localparam int LW = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] tap_q;
  logic [LW-1:0] lat_q;
  logic [31:0]   dline_q [NTAPS];
  logic [31:0]   coef_q  [NTAPS];
  logic [31:0]   x_q;
  logic [31:0]   h_q;
  logic          op_q;
  logic          m_valid_q;
  logic [31:0]   m_data_q;

  logic flush;
  logic idle;
  logic accept;

`ifdef FIR_TAP_SEQ_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign idle      = (state_q == IDLE);
  assign s_ready_o = idle && !flush;
  assign accept    = s_valid_i && s_ready_o && ce_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      lat_q     <= '0;
      x_q       <= '0;
      h_q       <= '0;
      op_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else if (ce_i) begin
      // coefficients only change between samples
      if (idle && coef_we_i) begin
        coef_q[coef_addr_i] <= coef_data_i;
      end
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < NTAPS; i++) begin
              dline_q[i] <= '0;
            end
          end else if (accept) begin
            dline_q[0] <= s_data_i;
            for (int i = 1; i < NTAPS; i++) begin
              dline_q[i] <= dline_q[i-1];
            end
            tap_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q  <= dline_q[tap_q];
          h_q  <= coef_q[tap_q];
          op_q <= (tap_q == '0);
          if (tap_q == AW'(NTAPS - 1)) begin
            lat_q   <= '0;
            state_q <= DRAIN;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        DRAIN: begin
          // zero products keep the running sum while the DSP pipe empties
          x_q  <= '0;
          h_q  <= '0;
          op_q <= 1'b0;
          if (lat_q == LW'(DSP_LAT - 1)) begin
            m_data_q  <= y_i;
            m_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_o            = x_q;
  assign h_o            = h_q;
  assign fpopmode_bit_o = op_q;
  assign m_valid_o      = m_valid_q;
  assign m_data_o       = m_data_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural FP MAC on x/h/y.
module tb_fir_tap_sequencer;

  localparam int NTAPS = 4;
  localparam int DLAT  = 4;
  localparam int LIM   = 40;

  localparam logic [31:0] F0  = 32'h00000000;
  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F7  = 32'h40E00000;
  localparam logic [31:0] F10 = 32'h41200000;
  localparam logic [31:0] F16 = 32'h41800000;
  localparam logic [31:0] F20 = 32'h41A00000;
  localparam logic [31:0] F25 = 32'h41C80000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [31:0] x_o;
  logic [31:0] h_o;
  logic        fp;
  logic [31:0] y;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;

  int errors = 0;
  int checks = 0;

  logic        tap0_op;
  logic [31:0] tap0_x;
  logic        stall_ok;

  fir_tap_sequencer #(.NTAPS(NTAPS), .DSP_LAT(DLAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ce_i           (ce),
    .coef_we_i      (coef_we),
    .coef_addr_i    (coef_addr),
    .coef_data_i    (coef_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .s_data_i       (s_data),
    .x_o            (x_o),
    .h_o            (h_o),
    .fpopmode_bit_o (fp),
    .y_i            (y),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    if (b[30:0] == 31'd0) return 0.0;
    return $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // FP MAC model: accumulation of a tap is visible on y DLAT edges later
  real         acc = 0.0;
  logic [31:0] pipe [DLAT-1];
  initial for (int i = 0; i < DLAT-1; i++) pipe[i] = '0;
  assign y = pipe[DLAT-2];

  always @(posedge clk) begin
    if (ce) begin
      if (fp) acc = f2r(x_o) * f2r(h_o);
      else    acc = acc + f2r(x_o) * f2r(h_o);
      pipe[0] <= r2f(acc);
      for (int i = 1; i < DLAT-1; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk); coef_we = 1'b0;
  endtask

  task automatic pop();
    m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
  endtask

  // inj: 1 coef write in RUN, 2 ce stall, 3 reset in DRAIN, 4 same-edge write
  task automatic send(input logic [31:0] d, input int inj,
                      output int lat, output logic [31:0] res);
    logic [31:0] xs, hs;
    @(negedge clk);
    s_valid = 1'b1; s_data = d;
    if (inj == 4) begin
      coef_we = 1'b1; coef_addr = 2'd1; coef_data = F0;
    end
    @(negedge clk);
    s_valid = 1'b0; coef_we = 1'b0;
    lat = 0; stall_ok = 1'b1;
    while (!m_valid && lat < LIM) begin
      if (inj == 1) begin
        coef_we = (lat == 1); coef_addr = 2'd0; coef_data = F7;
      end
      if (inj == 3) rst = (lat == 5);
      if (inj == 2 && lat == 2) begin
        xs = x_o; hs = h_o; ce = 1'b0;
        repeat (3) begin
          @(negedge clk); lat++;
          if (x_o !== xs || h_o !== hs) stall_ok = 1'b0;
        end
        ce = 1'b1;
      end
      @(negedge clk); lat++;
      if (lat == 1) begin tap0_op = fp; tap0_x = x_o; end
    end
    coef_we = 1'b0; rst = 1'b0;
    res = m_data;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    if (m_data !== F0) begin errors++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    if (x_o !== F0) begin errors++; $display("FAIL rst_x got=%h exp=0", x_o); end
    if (h_o !== F0) begin errors++; $display("FAIL rst_h got=%h exp=0", h_o); end
    if (fp !== 1'b0) begin errors++; $display("FAIL rst_fp got=%b exp=0", fp); end
  endtask

  task automatic test_impulse();
    logic [31:0] smp [5];
    logic [31:0] exp_y [5];
    int lat;
    logic [31:0] r;
    smp   = '{F1, F0, F0, F0, F0};
    exp_y = '{F5, F7, F1, F5, F0};
    wcoef(2'd0, F5); wcoef(2'd1, F7); wcoef(2'd2, F1); wcoef(2'd3, F5);
    for (int i = 0; i < 5; i++) begin
      send(smp[i], 0, lat, r);
      checks += 2;
      if (r !== exp_y[i]) begin errors++; $display("FAIL impulse_y%0d got=%h exp=%h", i, r, exp_y[i]); end
      if (lat !== 8) begin errors++; $display("FAIL impulse_lat%0d got=%0d exp=8", i, lat); end
      if (i == 0) begin
        checks += 2;
        if (tap0_op !== 1'b1) begin errors++; $display("FAIL tap0_fp got=%b exp=1", tap0_op); end
        if (tap0_x !== F1) begin errors++; $display("FAIL tap0_x got=%h exp=%h", tap0_x, F1); end
      end
      pop();
    end
  endtask

  task automatic test_constant();
    logic [31:0] exp_y [4];
    int lat;
    logic [31:0] r;
    exp_y = '{F5, F10, 32'h41700000, F20};
    do_reset();
    for (int i = 0; i < 4; i++) wcoef(2'(i), F1);
    for (int i = 0; i < 4; i++) begin
      send(F5, 0, lat, r);
      checks++;
      if (r !== exp_y[i]) begin errors++; $display("FAIL const_y%0d got=%h exp=%h", i, r, exp_y[i]); end
      pop();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] r;
    send(F5, 0, lat, r);
    checks++;
    if (r !== F20) begin errors++; $display("FAIL bp_y got=%h exp=%h", r, F20); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 3;
      if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%b exp=1", i, m_valid); end
      if (m_data !== F20) begin errors++; $display("FAIL bp_data%0d got=%h exp=%h", i, m_data, F20); end
      if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%b exp=0", i, s_ready); end
    end
    pop();
    checks += 2;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", s_ready); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", m_valid); end
  endtask

  task automatic test_coef_write();
    int lat;
    logic [31:0] r;
    send(F1, 1, lat, r);
    checks++;
    if (r !== F16) begin errors++; $display("FAIL coef_run_y got=%h exp=%h", r, F16); end
    pop();
    wcoef(2'd0, F7);
    send(F2, 0, lat, r);
    checks++;
    if (r !== F25) begin errors++; $display("FAIL coef_idle_y got=%h exp=%h", r, F25); end
    pop();
    send(F0, 4, lat, r);
    checks++;
    if (r !== F6) begin errors++; $display("FAIL coef_same_edge_y got=%h exp=%h", r, F6); end
    pop();
  endtask

  task automatic test_ce_stall();
    int lat;
    logic [31:0] r;
    send(F1, 2, lat, r);
    checks += 3;
    if (stall_ok !== 1'b1) begin errors++; $display("FAIL stall_frozen got=%b exp=1", stall_ok); end
    if (lat !== 11) begin errors++; $display("FAIL stall_lat got=%0d exp=11", lat); end
    if (r !== F10) begin errors++; $display("FAIL stall_y got=%h exp=%h", r, F10); end
    pop();
  endtask

  task automatic test_reset_drain();
    int lat;
    logic [31:0] r;
    send(F3, 3, lat, r);
    checks += 3;
    if (lat !== LIM) begin errors++; $display("FAIL rd_no_valid got_lat=%0d exp=%0d", lat, LIM); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got=%b exp=0", m_valid); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got=%b exp=1", s_ready); end
    send(F3, 0, lat, r);
    checks += 2;
    if (r !== F0) begin errors++; $display("FAIL rd_next_y got=%h exp=%h", r, F0); end
    if (lat !== 8) begin errors++; $display("FAIL rd_next_lat got=%0d exp=8", lat); end
    pop();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_constant();
    test_backpressure();
    test_coef_write();
    test_ce_stall();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
